// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues imem reads, steers the PC register and hands fetched words to decode.
// Optional FETCH_SKID_EN adds a one-entry skid buffer that absorbs a fetch returning while decode is stalled.
module fetch_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] current_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        pc_stall,
    output logic        pc_seq,
    output logic [31:0] jb_pc,
    output logic        flush,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    logic        req_out;
    logic [31:0] req_addr;
    logic        skid_valid;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;

    logic        ack_hit;
    logic        ack_take;
    logic        ack_skid;
    logic        can_issue;
    logic [31:0] issue_addr;

    // imem handshake: imem_req rises with imem_addr and both hold until the cycle imem_ack=1 completes it.
    assign imem_req  = req_out;
    assign imem_addr = req_addr;
    assign state_dbg = state;

    assign ack_hit  = req_out && imem_ack;
    assign ack_take = (state == FETCH) && ack_hit && !redirect_valid && !dec_stall;
`ifdef FETCH_SKID_EN
    assign ack_skid = (state == FETCH) && ack_hit && !redirect_valid && dec_stall;
`else
    assign ack_skid = 1'b0;
`endif

    // On an accepted ack the PC advances this edge, so the follow-on request targets current_pc+4.
    assign can_issue  = (state == FETCH) && !redirect_valid && !dec_stall && !skid_valid &&
                        (!req_out || ack_take);
    assign issue_addr = ack_take ? (current_pc + 32'd4) : current_pc;

    assign pc_stall = rst ? 1'b1 : !(redirect_valid || ack_take || ack_skid);
    assign pc_seq   = rst ? 1'b1 : !redirect_valid;
    assign jb_pc    = redirect_pc;
    assign flush    = !rst && redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_out    <= 1'b0;
            req_addr   <= 32'd0;
            if_valid   <= 1'b0;
            if_inst    <= 32'd0;
            if_pc      <= 32'd0;
            skid_valid <= 1'b0;
            skid_inst  <= 32'd0;
            skid_pc    <= 32'd0;
        end else begin
            case (state)
                IDLE:    state <= FETCH;
                FETCH:   if (redirect_valid && req_out && !imem_ack) state <= DROP;
                DROP:    if (imem_ack) state <= FETCH;
                default: state <= IDLE;
            endcase

            if (can_issue) begin
                req_out  <= 1'b1;
                req_addr <= issue_addr;
            end else if (ack_hit) begin
                req_out <= 1'b0;
            end

            if (redirect_valid) begin
                if_valid <= 1'b0;
            end else if (!dec_stall) begin
                if (skid_valid) begin
                    if_valid <= 1'b1;
                    if_inst  <= skid_inst;
                    if_pc    <= skid_pc;
                end else if (ack_take) begin
                    if_valid <= 1'b1;
                    if_inst  <= imem_rdata;
                    if_pc    <= req_addr;
                end else begin
                    if_valid <= 1'b0;
                end
            end

            // Skid drains into if_* on the first unstalled cycle; a redirect kills it.
            if (redirect_valid) begin
                skid_valid <= 1'b0;
            end else if (ack_skid) begin
                skid_valid <= 1'b1;
                skid_inst  <= imem_rdata;
                skid_pc    <= req_addr;
            end else if (!dec_stall) begin
                skid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; models the external PC register and checks hand-computed values.
// Define FETCH_SKID_EN for both bench and RTL to exercise the skid-buffer build.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_pc = 32'd0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_stall;
    logic        pc_seq;
    logic [31:0] jb_pc;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [1:0]  state_dbg;

    logic        pc_load = 1'b0;
    logic [31:0] pc_load_val = 32'd0;

    int total = 0;
    int bad = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .current_pc(current_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_stall(dec_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_stall(pc_stall), .pc_seq(pc_seq), .jb_pc(jb_pc), .flush(flush),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Core PC register driven by the sequencer's control outputs.
    always @(posedge clk) begin
        if (pc_load) current_pc <= pc_load_val;
        else if (rst) current_pc <= 32'd0;
        else if (!pc_stall) current_pc <= pc_seq ? current_pc + 32'd4 : jb_pc;
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset, preload the PC, and leave the bench at the first FETCH cycle.
    task automatic start(input logic [31:0] addr);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; dec_stall = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'd0; pc_load = 1'b0;
        tick; tick;
        rst = 1'b0; pc_load = 1'b1; pc_load_val = addr;
        tick;
        pc_load = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; dec_stall = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h1; pc_load = 1'b0;
        tick; tick;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%h want=0", imem_req); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_ifv got=%h want=0", if_valid); end
        total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL rst_state got=%h want=%h", state_dbg, S_IDLE); end
        total++; if (pc_stall !== 1'b1) begin bad++; $display("FAIL rst_pcstall got=%h want=1", pc_stall); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%h want=0", flush); end
        rst = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
        tick;
        total++; if (state_dbg !== S_FETCH) begin bad++; $display("FAIL rst_to_fetch got=%h want=%h", state_dbg, S_FETCH); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_fetch_req got=%h want=0", imem_req); end
    endtask

    task automatic test_zero_wait;
        start(32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h00000013;
        tick;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL zw_req[%0d] got=%h want=1", k, imem_req); end
            total++; if (imem_addr !== 32'(4 * k)) begin bad++; $display("FAIL zw_addr[%0d] got=%h want=%h", k, imem_addr, 32'(4 * k)); end
            total++; if (pc_stall !== 1'b0 || pc_seq !== 1'b1) begin bad++; $display("FAIL zw_pcctl[%0d] got=%b%b want=01", k, pc_stall, pc_seq); end
            if (k > 0) begin
                total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL zw_ifv[%0d] got=%h want=1", k, if_valid); end
                total++; if (if_pc !== 32'(4 * (k - 1))) begin bad++; $display("FAIL zw_ifpc[%0d] got=%h want=%h", k, if_pc, 32'(4 * (k - 1))); end
                total++; if (if_inst !== 32'h00000013) begin bad++; $display("FAIL zw_inst[%0d] got=%h want=00000013", k, if_inst); end
            end
            tick;
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_wait;
        start(32'h10);
        imem_ack = 1'b0;
        tick;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin bad++; $display("FAIL wt_hold[%0d] got=%b/%h want=1/10", k, imem_req, imem_addr); end
            total++; if (pc_stall !== 1'b1) begin bad++; $display("FAIL wt_pcstall[%0d] got=%h want=1", k, pc_stall); end
            tick;
        end
        imem_ack = 1'b1; imem_rdata = 32'h00A00093;
        #1;
        total++; if (pc_stall !== 1'b0) begin bad++; $display("FAIL wt_ack_pcstall got=%h want=0", pc_stall); end
        tick;
        imem_ack = 1'b0;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h10) begin bad++; $display("FAIL wt_ifpc got=%b/%h want=1/10", if_valid, if_pc); end
        total++; if (if_inst !== 32'h00A00093) begin bad++; $display("FAIL wt_inst got=%h want=00a00093", if_inst); end
    endtask

    task automatic test_redirect;
        start(32'h14);
        imem_ack = 1'b0;
        tick;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        total++; if (flush !== 1'b1 || pc_seq !== 1'b0 || pc_stall !== 1'b0) begin bad++; $display("FAIL rd_ctl got=%b%b%b want=100", flush, pc_seq, pc_stall); end
        total++; if (jb_pc !== 32'h200) begin bad++; $display("FAIL rd_jbpc got=%h want=200", jb_pc); end
        tick;
        redirect_valid = 1'b0;
        #1;
        total++; if (state_dbg !== S_DROP) begin bad++; $display("FAIL rd_drop got=%h want=%h", state_dbg, S_DROP); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin bad++; $display("FAIL rd_hold got=%b/%h want=1/14", imem_req, imem_addr); end
        total++; if (flush !== 1'b0 || pc_seq !== 1'b1) begin bad++; $display("FAIL rd_flush_once got=%b%b want=01", flush, pc_seq); end
        tick;
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        total++; if (pc_stall !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL rd_drop_ack got=%b%b want=10", pc_stall, flush); end
        tick;
        imem_ack = 1'b0;
        #1;
        total++; if (state_dbg !== S_FETCH || if_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL rd_back got=%h/%b/%b want=1/0/0", state_dbg, if_valid, imem_req); end
        tick;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL rd_newreq got=%b/%h want=1/200", imem_req, imem_addr); end
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        #1;
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL rd_ack_same got=%h want=1", flush); end
        tick;
        imem_ack = 1'b0; redirect_valid = 1'b0;
        #1;
        total++; if (state_dbg !== S_FETCH || if_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL rd_same_discard got=%h/%b/%b want=1/0/0", state_dbg, if_valid, imem_req); end
        tick;
        total++; if (imem_addr !== 32'h300 || imem_req !== 1'b1) begin bad++; $display("FAIL rd_same_next got=%b/%h want=1/300", imem_req, imem_addr); end
    endtask

    task automatic test_dec_stall;
        start(32'h4);
        imem_ack = 1'b1; imem_rdata = 32'h11;
        tick;
        tick;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || imem_addr !== 32'h8) begin bad++; $display("FAIL ds_pre got=%b/%h/%h want=1/4/8", if_valid, if_pc, imem_addr); end
        dec_stall = 1'b1; imem_rdata = 32'h22;
        #1;
`ifdef FETCH_SKID_EN
        total++; if (pc_stall !== 1'b0 || pc_seq !== 1'b1) begin bad++; $display("FAIL ds_skid_pc got=%b%b want=01", pc_stall, pc_seq); end
`else
        total++; if (pc_stall !== 1'b1) begin bad++; $display("FAIL ds_hold_pc got=%h want=1", pc_stall); end
`endif
        tick;
        imem_ack = 1'b0;
        #1;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || imem_req !== 1'b0) begin bad++; $display("FAIL ds_hold1 got=%b/%h/%b want=1/4/0", if_valid, if_pc, imem_req); end
        tick;
        dec_stall = 1'b0;
        #1;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin bad++; $display("FAIL ds_hold2 got=%b/%h want=1/4", if_valid, if_pc); end
        tick;
`ifdef FETCH_SKID_EN
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== 32'h22) begin bad++; $display("FAIL ds_skid_out got=%b/%h/%h want=1/8/22", if_valid, if_pc, if_inst); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ds_skid_noreq got=%h want=0", imem_req); end
        tick;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin bad++; $display("FAIL ds_skid_next got=%b/%h want=1/c", imem_req, imem_addr); end
`else
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL ds_consumed got=%h want=0", if_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL ds_refetch got=%b/%h want=1/8", imem_req, imem_addr); end
        imem_ack = 1'b1;
        tick;
        imem_ack = 1'b0;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== 32'h22) begin bad++; $display("FAIL ds_refetch_out got=%b/%h/%h want=1/8/22", if_valid, if_pc, if_inst); end
`endif
    endtask

    task automatic test_reset_mid;
        start(32'h3C);
        imem_ack = 1'b1; imem_rdata = 32'h33;
        tick;
        tick;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b/%h/%b want=1/40/1", imem_req, imem_addr, if_valid); end
        rst = 1'b1;
        #1;
        total++; if (pc_stall !== 1'b1 || flush !== 1'b0) begin bad++; $display("FAIL rm_rst_ctl got=%b%b want=10", pc_stall, flush); end
        tick;
        rst = 1'b0; imem_ack = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || state_dbg !== S_IDLE) begin bad++; $display("FAIL rm_cleared got=%b/%b/%h want=0/0/0", imem_req, if_valid, state_dbg); end
        tick;
        tick;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rm_first got=%b/%h want=1/0", imem_req, imem_addr); end
    endtask

    task automatic test_wrap;
        start(32'hFFFFFFFC);
        imem_ack = 1'b1; imem_rdata = 32'h73;
        tick;
        #1;
        total++; if (imem_addr !== 32'hFFFFFFFC || pc_stall !== 1'b0 || pc_seq !== 1'b1) begin bad++; $display("FAIL wr_req got=%h/%b%b want=fffffffc/01", imem_addr, pc_stall, pc_seq); end
        tick;
        imem_ack = 1'b0;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFFFFFC) begin bad++; $display("FAIL wr_ifpc got=%b/%h want=1/fffffffc", if_valid, if_pc); end
        total++; if (imem_addr !== 32'h0 || current_pc !== 32'h0) begin bad++; $display("FAIL wr_wrap got=%h/%h want=0/0", imem_addr, current_pc); end
    endtask

    initial begin
        test_reset;
        test_zero_wait;
        test_wait;
        test_redirect;
        test_dec_stall;
        test_reset_mid;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, sync active-high reset.
REQ-004 SHALL have port current_pc, input, 32, present value of the PC register.
REQ-005 SHALL have port redirect_valid, input, 1, taken branch/jump from EX.
REQ-006 SHALL have port redirect_pc, input, 32, redirect target.
REQ-007 SHALL have port dec_stall, input, 1, decode cannot accept (load-use/downstream hold).
REQ-008 SHALL have port imem_req, output, 1, instruction memory request.
REQ-009 SHALL have port imem_addr, output, 32, request address.
REQ-010 SHALL have port imem_ack, input, 1, read data valid.
REQ-011 SHALL have port imem_rdata, input, 32, instruction word.
REQ-012 SHALL have port pc_stall, output, 1, PC register hold.
REQ-013 SHALL have port pc_seq, output, 1, 1 = PC+4, 0 = load jb_pc.
REQ-014 SHALL have port jb_pc, output, 32, PC load value.
REQ-015 SHALL have port flush, output, 1, one-cycle pipeline kill.
REQ-016 SHALL have ports if_valid, if_inst and if_pc, outputs, 1/32/32, registered fetch result to decode.

Function
REQ-017 SHALL implement states IDLE, FETCH, DROP.
- IDLE -> FETCH unconditionally, one cycle after reset release.
REQ-018 SHALL issue a request only in FETCH with no request outstanding and dec_stall=0.
- On issue, latch req_addr=current_pc.
- imem_req=1 and imem_addr=req_addr, both held stable until imem_ack.
REQ-019 SHALL, on imem_ack in FETCH with redirect_valid=0 and dec_stall=0:
- pc_stall=0, pc_seq=1 that cycle.
- Next cycle: if_valid=1, if_inst=imem_rdata, if_pc=req_addr.
- Back-to-back requests allowed: one instruction per cycle with zero-wait memory.
REQ-020 SHALL otherwise hold the PC (pc_stall=1) whenever no redirect and no accepted ack occur.
REQ-021 SHALL hold if_valid/if_inst/if_pc unchanged while dec_stall=1; if_valid clears after a consumed cycle with no new instruction.
REQ-022 SHALL give redirect_valid priority over all other events:
- pc_stall=0, pc_seq=0, jb_pc=redirect_pc, flush=1 for exactly that cycle.
- if_valid=0 next cycle.
REQ-023 SHALL handle redirect against an outstanding request:
- No ack that cycle: enter DROP; keep imem_req/imem_addr stable until ack; discard data; PC held; then return to FETCH.
- Ack that same cycle: discard data and stay in FETCH.
REQ-024 SHALL ignore a second redirect_valid while in DROP only by reloading the PC (jb_pc=redirect_pc, flush=1) and remaining in DROP.
REQ-025 SHALL drive jb_pc=redirect_pc and flush=0 in all cycles without redirect; pc_seq=1 outside redirect cycles.
REQ-026 SHALL compute all addresses modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).

Reset
REQ-027 SHALL, on rst=1 at a clock edge, enter IDLE.
- Clear request-outstanding, if_valid, if_inst, if_pc, req_addr and skid.
- Outputs: imem_req=0, flush=0, pc_stall=1.
- Any in-flight ack is ignored.

Configuration
REQ-028 SHALL support macro FETCH_SKID_EN.
- Defined: a 1-entry skid buffer captures an ack arriving while dec_stall=1 and if_valid=1; PC advances (pc_seq=1, pc_stall=0); skid drains to if_* on the first cycle dec_stall=0; no new request is issued while skid is full; redirect clears skid.
- Undefined: such an ack is discarded, PC held (pc_stall=1), and the same address is refetched after dec_stall clears.

Verification
REQ-029 Reset then zero-wait ack each cycle, rdata=0x00000013 -> requests 0x0,0x4,0x8; if_pc 0x0,0x4,0x8 on consecutive cycles.
REQ-030 Ack delayed 3 cycles at PC 0x10 -> imem_addr stays 0x10, pc_stall=1 for 3 cycles, if_pc=0x10 after ack.
REQ-031 redirect_valid, redirect_pc=0x200, with request at 0x14 outstanding, ack 2 cycles later -> flush=1 once, pc_seq=0, DROP, data discarded, next request 0x200.
REQ-032 dec_stall=1 for 2 cycles while ack returns for 0x8 -> with FETCH_SKID_EN: if_pc=0x8 after stall and no refetch; without: refetch 0x8 after stall.
REQ-033 rst asserted mid-request at 0x40 -> imem_req=0 and if_valid=0 next cycle; first post-reset request at 0x0.
REQ-034 current_pc=0xFFFFFFFC with ack -> PC wraps to 0x00000000, if_pc=0xFFFFFFFC.
